// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  localparam int MAX_REG_W = 8;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b01;
  typedef struct packed {
    logic [MAX_REG_W-1:0] rd;
    logic [MAX_REG_W-1:0] rs1;
    logic [MAX_REG_W-1:0] rs2;
    logic reg_write;
    logic mem_read;
  } ex_shadow_t;
  typedef struct packed {
    logic [MAX_REG_W-1:0] rd;
    logic reg_write;
  } wb_shadow_t;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority compare of one EX source register against MEM and WB writers
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [MAX_REG_W-1:0] src,
  input  wb_shadow_t           mem,
  input  wb_shadow_t           wb,
  output logic [1:0]           sel
);
  assign sel = (mem.reg_write && mem.rd != '0 && mem.rd == src) ? FWD_MEM :
               (wb.reg_write && wb.rd != '0 && wb.rd == src) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall, branch flush, forwarding and halt/drain control
module hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             mem_branch_taken,
  input  logic             halt,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             wb_bypass_a,
  output logic             wb_bypass_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) + 1 : 1;
  state_t state, state_n;
  logic [DW-1:0] dcnt;
  ex_shadow_t ex;
  wb_shadow_t mem, wb;
  logic [MAX_REG_W-1:0] rs1, rs2, rd;
  logic load_use, stop;
  assign rs1 = MAX_REG_W'(id_rs1);
  assign rs2 = MAX_REG_W'(id_rs2);
  assign rd = MAX_REG_W'(id_rd);
  assign load_use = ex.mem_read && ex.rd != '0 &&
                    ((id_use_rs1 && ex.rd == rs1) || (id_use_rs2 && ex.rd == rs2));
  // A stall in RUN only comes from load-use; DRAIN and HALTED always hold the front end.
  assign stop = state != RUN || load_use;
  // A taken branch overrides every hold so the branch target is always captured.
  assign pc_write = mem_branch_taken || !stop;
  assign ifid_write = mem_branch_taken || !stop;
  assign ifid_flush = mem_branch_taken;
  assign idex_bubble = mem_branch_taken || stop;
  assign exmem_flush = mem_branch_taken;
  assign halted = state == HALTED;
  assign wb_bypass_a = wb.reg_write && wb.rd != '0 && id_use_rs1 && wb.rd == rs1;
  assign wb_bypass_b = wb.reg_write && wb.rd != '0 && id_use_rs2 && wb.rd == rs2;
  fwd_select u_fwd_a (.src(ex.rs1), .mem(mem), .wb(wb), .sel(forward_a));
  fwd_select u_fwd_b (.src(ex.rs2), .mem(mem), .wb(wb), .sel(forward_b));
  // Next state: dropping halt always resumes; drain ends after DRAIN_CYCLES bubbles.
  always_comb begin
    state_n = state == RUN ? (halt ? DRAIN : RUN) :
              !halt ? RUN :
              (state == DRAIN && dcnt == DW'(DRAIN_CYCLES - 1)) ? HALTED : state;
  end
  // Shadow pipeline, FSM state, drain counter and event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      dcnt <= '0;
      ex <= '0;
      mem <= '0;
      wb <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_n;
      dcnt <= state == DRAIN ? dcnt + 1'b1 : '0;
      ex <= idex_bubble ? '0 : ex_shadow_t'{rd: rd, rs1: rs1, rs2: rs2,
                                            reg_write: id_reg_write, mem_read: id_mem_read};
      mem <= exmem_flush ? '0 : wb_shadow_t'{rd: ex.rd, reg_write: ex.reg_write};
      wb <= mem;
      stall_count <= stall_count + CNT_W'(state == RUN && load_use && !mem_branch_taken);
      flush_count <= flush_count + CNT_W'(mem_branch_taken);
    end
  end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed and random checks against a behavioural pipeline model
module tb_hazard_controller;
  logic clk = 0, reset = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, id_reg_write = 0, id_mem_read = 0;
  logic mem_branch_taken = 0, halt = 0;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush;
  logic [1:0] forward_a, forward_b;
  logic wb_bypass_a, wb_bypass_b, halted;
  logic [3:0] stall_count, flush_count;
  int errors = 0, checks = 0;

  hazard_controller #(.REG_W(5), .CNT_W(4), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .mem_branch_taken(mem_branch_taken), .halt(halt),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
    .forward_a(forward_a), .forward_b(forward_b),
    .wb_bypass_a(wb_bypass_a), .wb_bypass_b(wb_bypass_b), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {int rd; int rs1; int rs2; bit rw; bit mr;} instr_t;
  instr_t pipe [3];
  int mode, drained, stalls, flushes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fwd(input int src);
    if (pipe[1].rw && pipe[1].rd != 0 && pipe[1].rd == src) return 2;
    if (pipe[2].rw && pipe[2].rd != 0 && pipe[2].rd == src) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    instr_t z = '{0, 0, 0, 0, 0};
    pipe = '{z, z, z};
    mode = 0; drained = 0; stalls = 0; flushes = 0;
  endtask

  task automatic set_id(input int rd, input int rs1, input int rs2, input bit u1, input bit u2,
                        input bit rw, input bit mr);
    id_rd = 5'(rd); id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic cyc();
    bit lu, hold, br;
    instr_t z = '{0, 0, 0, 0, 0};
    #1;
    br = mem_branch_taken;
    lu = pipe[0].mr && pipe[0].rd != 0 &&
         ((id_use_rs1 && pipe[0].rd == int'(id_rs1)) || (id_use_rs2 && pipe[0].rd == int'(id_rs2)));
    hold = mode != 0 || lu;
    chk("pc_write", 32'(pc_write), 32'(br || !hold));
    chk("ifid_write", 32'(ifid_write), 32'(br || !hold));
    chk("ifid_flush", 32'(ifid_flush), 32'(br));
    chk("idex_bubble", 32'(idex_bubble), 32'(br || hold));
    chk("exmem_flush", 32'(exmem_flush), 32'(br));
    chk("forward_a", 32'(forward_a), 32'(fwd(pipe[0].rs1)));
    chk("forward_b", 32'(forward_b), 32'(fwd(pipe[0].rs2)));
    chk("wb_bypass_a", 32'(wb_bypass_a),
        32'(pipe[2].rw && pipe[2].rd != 0 && id_use_rs1 && pipe[2].rd == int'(id_rs1)));
    chk("wb_bypass_b", 32'(wb_bypass_b),
        32'(pipe[2].rw && pipe[2].rd != 0 && id_use_rs2 && pipe[2].rd == int'(id_rs2)));
    chk("halted", 32'(halted), 32'(mode == 2));
    chk("stall_count", 32'(stall_count), 32'(stalls % 16));
    chk("flush_count", 32'(flush_count), 32'(flushes % 16));
    @(posedge clk);
    if (reset) model_reset();
    else begin
      if (mode == 0 && lu && !br) stalls++;
      if (br) flushes++;
      pipe[2] = pipe[1];
      pipe[1] = br ? z : '{pipe[0].rd, 0, 0, pipe[0].rw, 0};
      pipe[0] = (br || hold) ? z : '{int'(id_rd), int'(id_rs1), int'(id_rs2), id_reg_write, id_mem_read};
      if (!halt) mode = 0;
      else if (mode == 0) begin mode = 1; drained = 0; end
      else if (mode == 1) begin
        drained++;
        if (drained == 3) mode = 2;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; cyc(); reset = 0;
  endtask

  initial begin
    reset = 1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    model_reset();
    do_reset();
    // 1: load followed by a dependent add
    set_id(5, 0, 0, 0, 0, 1, 1); cyc();
    set_id(6, 5, 7, 1, 1, 1, 0); #1 chk("t1_stall_pc", 32'(pc_write), 0);
    chk("t1_stall_bubble", 32'(idex_bubble), 1);
    cyc(); cyc();
    set_id(0, 0, 0, 0, 0, 0, 0); #1 chk("t1_fwd_wb", 32'(forward_a), 32'b01);
    chk("t1_stall_count", 32'(stall_count), 1);
    cyc();
    // 2: back-to-back ALU, then an x0 producer
    do_reset();
    set_id(3, 0, 0, 0, 0, 1, 0); cyc();
    set_id(4, 3, 3, 1, 1, 1, 0); #1 chk("t2_no_stall", 32'(pc_write), 1);
    cyc();
    set_id(0, 0, 0, 0, 0, 0, 0); #1 chk("t2_fwd_a", 32'(forward_a), 32'b10);
    chk("t2_fwd_b", 32'(forward_b), 32'b10);
    cyc();
    set_id(0, 0, 0, 0, 0, 1, 0); cyc();
    set_id(4, 0, 0, 1, 1, 1, 0); cyc();
    set_id(0, 0, 0, 0, 0, 0, 0); #1 chk("t2_x0_fwd_a", 32'(forward_a), 0);
    chk("t2_x0_fwd_b", 32'(forward_b), 0);
    cyc();
    // 3: MEM and WB both write x9
    set_id(9, 0, 0, 0, 0, 1, 0); cyc(); cyc();
    set_id(1, 9, 0, 1, 0, 1, 0); cyc();
    set_id(0, 0, 0, 0, 0, 0, 0); #1 chk("t3_mem_prio", 32'(forward_a), 32'b10);
    cyc();
    // 4: taken branch coincident with load-use
    do_reset();
    set_id(5, 0, 0, 0, 0, 1, 1); cyc();
    set_id(6, 5, 0, 1, 0, 1, 0); mem_branch_taken = 1;
    #1 chk("t4_pc_write", 32'(pc_write), 1);
    chk("t4_ifid_flush", 32'(ifid_flush), 1);
    chk("t4_exmem_flush", 32'(exmem_flush), 1);
    cyc();
    mem_branch_taken = 0; set_id(0, 0, 0, 0, 0, 0, 0);
    #1 chk("t4_flush_count", 32'(flush_count), 1);
    chk("t4_stall_count", 32'(stall_count), 0);
    cyc();
    // 5: halt, drain, resume, then reset mid-drain
    do_reset();
    halt = 1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t5_halted", 32'(halted), 32'(i == 4));
      cyc();
    end
    halt = 0; #1 chk("t5_still_held", 32'(pc_write), 0);
    cyc();
    #1 chk("t5_resume_pc", 32'(pc_write), 1);
    cyc();
    set_id(5, 0, 0, 0, 0, 1, 1); cyc();
    set_id(6, 5, 0, 1, 0, 1, 0); cyc();
    set_id(0, 0, 0, 0, 0, 0, 0); halt = 1; cyc(); cyc();
    reset = 1; cyc(); reset = 0; halt = 0;
    #1 chk("t5_reset_run", 32'(pc_write), 1);
    chk("t5_reset_cnt", 32'(stall_count), 0);
    cyc();
    // 6: 17 stalls wrap a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_id(5, 0, 0, 0, 0, 1, 1); cyc();
      set_id(6, 5, 5, 1, 1, 1, 0); cyc();
      set_id(0, 0, 0, 0, 0, 0, 0); cyc();
    end
    #1 chk("t6_wrap", 32'(stall_count), 1);
    cyc();
    // random traffic against the model
    for (int i = 0; i < 500; i++) begin
      set_id($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
      mem_branch_taken = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      reset = ($urandom_range(0, 59) == 0);
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
